fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
// Parametrised, decoupled instruction-fetch stage. Issues one request per cycle to a synchronous
// instruction memory and predecodes each returned word for JAL, taken-predicted BRANCH/FBRANCH
// and 64-bit instructions. Keeps a global branch history and buffers fetched bundles in a
// DEPTH-entry FIFO. Decode pulls bundles through a valid/ready handshake. Sits between imem and decode.
// PARAMETERS
// XLEN      32  address/instruction width
// DEPTH     4   bundle FIFO entries (power of 2, >=2)
// GHR_BITS  8   global history length = predictor index width
// RESET_PC  0   first fetch address after reset
// PORTS
// clk            in   1         clock
// rst            in   1         synchronous reset, active-high
// imem_req       out  1         request valid this cycle
// imem_addr      out  XLEN      request address (combinational)
// imem_rdata     in   XLEN      word at address issued last cycle
// imem_rdata1    in   XLEN      following word (second half of 64-bit instr)
// pht_idx        out  GHR_BITS  predictor index = resp_pc[GHR_BITS+1:2] ^ ghr
// pred_taken     in   1         predictor outcome for pht_idx (same cycle)
// redirect       in   1         back-end mispredict/jump miss; flush
// redirect_pc    in   XLEN      correct next PC
// redirect_ghr   in   GHR_BITS  corrected history to restore
// out_valid      out  1         FIFO head valid
// out_ready      in   1         decode accepts head
// out_pc         out  XLEN      bundle PC
// out_instr      out  XLEN      bundle word 0
// out_instr1     out  XLEN      bundle word 1
// out_pht_idx    out  GHR_BITS  index used at predecode (for predictor update)
// out_pred_taken out  1         1 if predecode redirected (JAL or taken branch)
// BEHAVIOUR
// - State: req_pc_q, inflight_q, next_pc_q, ghr_q, FIFO (rd/wr ptr, count 0..DEPTH).
// - Reset: inflight_q=0, next_pc_q=RESET_PC, ghr_q=0, FIFO empty. imem_req=0 and out_valid=0 while rst=1.
// - Response valid (resp_v) = inflight_q. resp_pc = req_pc_q.
// - Predecode on resp_v: jal = op==1101111. br = op==1100011|1100001. i64 = rdata[0]==0.
//   pred_next = jal ? pc+imm_j : (br&pred_taken) ? pc+imm_b : i64 ? pc+8 : pc+4 (mod 2^XLEN).
// - imem_addr = redirect ? redirect_pc : resp_v ? pred_next : next_pc_q.
// - issue_ok = (count + inflight_q) < DEPTH, from registered values only.
//   imem_req = !rst & (redirect | issue_ok).
// - Issued: req_pc_q<=imem_addr, inflight_q<=1. Else inflight_q<=0, next_pc_q<=imem_addr (held).
// - Enqueue when resp_v & !redirect. The credit rule guarantees space; overflow is illegal (assert).
// - GHR: on redirect ghr_q<=redirect_ghr. Else on resp_v&br: ghr_q<={ghr_q[GHR_BITS-2:0],pred_taken}.
// - Dequeue when out_valid&out_ready. Outputs come from the FIFO head; zero when empty.
// - Redirect has priority: same-cycle response dropped, FIFO emptied, dequeue ignored,
//   and a new request at redirect_pc issued in that cycle (count treated as 0).
// - Simultaneous enqueue+dequeue when full-minus-credit: count unchanged, no bubble.
// - Steady state with out_ready=1: one bundle per cycle. First bundle is out_valid 2 cycles after rst falls.
// - Reset asserted mid-operation: in-flight response discarded, all state to reset values next cycle.
// TESTING
// - Reset release, straight-line code (all pc+4): addr 0,4,8,... and out_pc 0,4,8 every cycle with out_ready=1.
// - JAL imm=+0x100 at pc 0x8: next imem_addr 0x108, out_pred_taken=1, ghr unchanged.
// - BRANCH at 0x10, imm=-8: pred_taken=1 gives next 0x8, ghr shifts in 1. pred_taken=0 gives 0x14, shifts in 0.
// - 64-bit instr (rdata[0]=0) at 0x20: next addr 0x28. out_instr1 equals imem_rdata1.
// - out_ready=0 for 10 cycles: count saturates at DEPTH, imem_req=0, no lost or duplicate PCs on release.
// - redirect with redirect_pc=0x400, ghr=0xA5 while FIFO holds 3: out_valid=0 next cycle, then out_pc=0x400, ghr=0xA5.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem, predictor, redirect and decode-side signals of the fetch stage
interface fetch_queue_if #(
  parameter int XLEN = 32,
  parameter int GHR_BITS = 8
);
  logic                imem_req;
  logic [XLEN-1:0]     imem_addr;
  logic [XLEN-1:0]     imem_rdata;
  logic [XLEN-1:0]     imem_rdata1;
  logic [GHR_BITS-1:0] pht_idx;
  logic                pred_taken;
  logic                redirect;
  logic [XLEN-1:0]     redirect_pc;
  logic [GHR_BITS-1:0] redirect_ghr;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [XLEN-1:0]     out_instr;
  logic [XLEN-1:0]     out_instr1;
  logic [GHR_BITS-1:0] out_pht_idx;
  logic                out_pred_taken;
  modport slave (
    output imem_req, imem_addr, pht_idx, out_valid, out_pc, out_instr, out_instr1,
           out_pht_idx, out_pred_taken,
    input  imem_rdata, imem_rdata1, pred_taken, redirect, redirect_pc, redirect_ghr, out_ready
  );
  modport master (
    input  imem_req, imem_addr, pht_idx, out_valid, out_pc, out_instr, out_instr1,
           out_pht_idx, out_pred_taken,
    output imem_rdata, imem_rdata1, pred_taken, redirect, redirect_pc, redirect_ghr, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction fetch with predecode, global history and bundle FIFO
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int GHR_BITS = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic                r_inflight;
  logic [XLEN-1:0]     r_req_pc;
  logic [XLEN-1:0]     r_next_pc;
  logic [GHR_BITS-1:0] r_ghr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW-1:0]       r_wr_ptr;
  logic [CW-1:0]       r_count;
  logic [XLEN-1:0]     r_pc_mem [DEPTH];
  logic [XLEN-1:0]     r_i0_mem [DEPTH];
  logic [XLEN-1:0]     r_i1_mem [DEPTH];
  logic [GHR_BITS-1:0] r_idx_mem [DEPTH];
  logic                r_tk_mem [DEPTH];
  logic [6:0]          w_op;
  logic                w_jal;
  logic                w_br;
  logic                w_i64;
  logic                w_taken;
  logic [XLEN-1:0]     w_imm_j;
  logic [XLEN-1:0]     w_imm_b;
  logic [XLEN-1:0]     w_pred_next;
  logic [XLEN-1:0]     w_addr;
  logic [GHR_BITS-1:0] w_pht_idx;
  logic                w_issue_ok;
  logic                w_issue;
  logic                w_valid;
  logic                w_enq;
  logic                w_deq;
  // predecode of the returning word and next-address selection
  always_comb begin
    w_op        = bus.imem_rdata[6:0];
    w_jal       = w_op == 7'b1101111;
    w_br        = w_op == 7'b1100011 || w_op == 7'b1100001;
    w_i64       = !bus.imem_rdata[0];
    w_taken     = w_jal || (w_br && bus.pred_taken);
    w_imm_j     = {{(XLEN-20){bus.imem_rdata[31]}}, bus.imem_rdata[19:12], bus.imem_rdata[20],
                   bus.imem_rdata[30:21], 1'b0};
    w_imm_b     = {{(XLEN-12){bus.imem_rdata[31]}}, bus.imem_rdata[7], bus.imem_rdata[30:25],
                   bus.imem_rdata[11:8], 1'b0};
    w_pred_next = w_jal ? r_req_pc + w_imm_j :
                  (w_br && bus.pred_taken) ? r_req_pc + w_imm_b :
                  w_i64 ? r_req_pc + XLEN'(8) : r_req_pc + XLEN'(4);
    w_addr      = bus.redirect ? bus.redirect_pc : r_inflight ? w_pred_next : r_next_pc;
    w_pht_idx   = r_req_pc[GHR_BITS+1:2] ^ r_ghr;
    w_issue_ok  = (r_count + CW'(r_inflight)) < CW'(DEPTH);
    w_issue     = !rst && (bus.redirect || w_issue_ok);
    w_valid     = !rst && r_count != '0;
    w_enq       = r_inflight && !bus.redirect;
    w_deq       = w_valid && bus.out_ready && !bus.redirect;
  end
  assign bus.imem_req       = w_issue;
  assign bus.imem_addr      = w_addr;
  assign bus.pht_idx        = w_pht_idx;
  assign bus.out_valid      = w_valid;
  assign bus.out_pc         = w_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign bus.out_instr      = w_valid ? r_i0_mem[r_rd_ptr] : '0;
  assign bus.out_instr1     = w_valid ? r_i1_mem[r_rd_ptr] : '0;
  assign bus.out_pht_idx    = w_valid ? r_idx_mem[r_rd_ptr] : '0;
  assign bus.out_pred_taken = w_valid && r_tk_mem[r_rd_ptr];
  // request tracking, held PC, history and FIFO occupancy; redirect flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_req_pc   <= RESET_PC;
      r_next_pc  <= RESET_PC;
      r_ghr      <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_req_pc <= w_addr;
      else r_next_pc <= w_addr;
      r_ghr    <= bus.redirect ? bus.redirect_ghr :
                  (r_inflight && w_br) ? {r_ghr[GHR_BITS-2:0], bus.pred_taken} : r_ghr;
      r_rd_ptr <= bus.redirect ? '0 : r_rd_ptr + AW'(w_deq);
      r_wr_ptr <= bus.redirect ? '0 : r_wr_ptr + AW'(w_enq);
      r_count  <= bus.redirect ? '0 : r_count + CW'(w_enq) - CW'(w_deq);
    end
  end
  // bundle storage; contents are only meaningful behind the occupancy count
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_mem[r_wr_ptr]  <= r_req_pc;
      r_i0_mem[r_wr_ptr]  <= bus.imem_rdata;
      r_i1_mem[r_wr_ptr]  <= bus.imem_rdata1;
      r_idx_mem[r_wr_ptr] <= w_pht_idx;
      r_tk_mem[r_wr_ptr]  <= w_taken;
    end
  end
  // the issue credit must never let a response arrive into a full FIFO
  always_ff @(posedge clk) begin
    if (!rst && w_enq && !w_deq) assert (r_count < CW'(DEPTH));
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard of expected bundles for fetch_queue
module tb_fetch_queue;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instr1;
    logic [7:0]  idx;
    logic        tk;
  } bundle_t;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] mem [4096];
  logic [31:0] tgt [4096];
  bit pt [4096];
  bit jalm [4096];
  bit brm [4096];
  bit len8 [4096];
  logic [31:0] r_addr = '0;
  bundle_t q [$];
  logic [31:0] m_pc;
  logic [7:0] m_ghr;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fetch_queue_if #(.XLEN(32), .GHR_BITS(8)) bus ();
  fetch_queue #(.XLEN(32), .DEPTH(4), .GHR_BITS(8), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always @(posedge clk) if (bus.imem_req) r_addr <= bus.imem_addr;
  assign bus.imem_rdata  = mem[r_addr[13:2]];
  assign bus.imem_rdata1 = mem[r_addr[13:2] + 12'd1];
  assign bus.pred_taken  = pt[r_addr[13:2]];
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bundle_t mk(logic [31:0] pc, logic [7:0] g);
    logic [11:0] i = pc[13:2];
    return '{pc, mem[i], mem[i + 12'd1], pc[9:2] ^ g, jalm[i] | (brm[i] & pt[i])};
  endfunction
  task automatic monitor();
    bundle_t e;
    bundle_t b;
    logic [11:0] i;
    if (rst) begin
      chk("rst_req", 64'(bus.imem_req), 64'd0);
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      q.delete();
      m_pc = 32'h0;
      m_ghr = 8'h0;
      return;
    end
    if (bus.redirect) begin
      q.delete();
      m_pc = bus.redirect_pc;
      m_ghr = bus.redirect_ghr;
    end else if (bus.out_valid && bus.out_ready) begin
      chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        b = q.pop_front();
        chk("out_pc", 64'(bus.out_pc), 64'(b.pc));
        chk("out_instr", 64'(bus.out_instr), 64'(b.instr));
        chk("out_instr1", 64'(bus.out_instr1), 64'(b.instr1));
        chk("out_pht_idx", 64'(bus.out_pht_idx), 64'(b.idx));
        chk("out_pred_taken", 64'(bus.out_pred_taken), 64'(b.tk));
      end
    end
    if (bus.imem_req) begin
      chk("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
      e = mk(m_pc, m_ghr);
      q.push_back(e);
      i = m_pc[13:2];
      if (brm[i]) m_ghr = {m_ghr[6:0], pt[i]};
      m_pc = e.tk ? tgt[i] : len8[i] ? m_pc + 32'd8 : m_pc + 32'd4;
    end
  endtask
  task automatic cycle(int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    for (int k = 0; k < 4096; k++) begin
      mem[k] = 32'h0000_0013;
      tgt[k] = 32'h0;
    end
    mem[2] = 32'h1000_006F;
    jalm[2] = 1'b1;
    tgt[2] = 32'h108;
    mem[4] = 32'hFE00_0CE3;
    brm[4] = 1'b1;
    pt[4] = 1'b1;
    tgt[4] = 32'h8;
    mem[8] = 32'h0000_1000;
    len8[8] = 1'b1;
    mem[9] = 32'h1234_5677;
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.redirect_ghr = 8'h0;
    bus.out_ready = 1'b1;
    cycle(3);
    rst = 1'b0;
    cycle(1);
    chk("first_valid_early", 64'(bus.out_valid), 64'd0);
    cycle(1);
    chk("first_valid", 64'(bus.out_valid), 64'd1);
    chk("first_pc", 64'(bus.out_pc), 64'h0);
    cycle(12);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h10;
    bus.redirect_ghr = 8'h00;
    cycle(1);
    bus.redirect = 1'b0;
    cycle(12);
    pt[4] = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h10;
    bus.redirect_ghr = 8'h3C;
    cycle(1);
    bus.redirect = 1'b0;
    cycle(14);
    bus.out_ready = 1'b0;
    cycle(10);
    chk("stall_req", 64'(bus.imem_req), 64'd0);
    chk("stall_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    cycle(12);
    bus.out_ready = 1'b0;
    cycle(2);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h400;
    bus.redirect_ghr = 8'hA5;
    cycle(1);
    bus.redirect = 1'b0;
    bus.out_ready = 1'b1;
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_pc_zero", 64'(bus.out_pc), 64'h0);
    cycle(1);
    chk("redir_valid", 64'(bus.out_valid), 64'd1);
    chk("redir_pc", 64'(bus.out_pc), 64'h400);
    chk("redir_ghr_idx", 64'(bus.out_pht_idx), 64'hA5);
    cycle(8);
    rst = 1'b1;
    cycle(2);
    rst = 1'b0;
    cycle(1);
    chk("rerst_valid_early", 64'(bus.out_valid), 64'd0);
    cycle(1);
    chk("rerst_valid", 64'(bus.out_valid), 64'd1);
    chk("rerst_pc", 64'(bus.out_pc), 64'h0);
    cycle(8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
